// File: rtl/pkt_release_scheduler.sv
// Packet release scheduler: pairs completed buffer packets with TCAM action decisions,
// pulses the buffer release, and gates egress during the drain. Optional macro: ACT_TIMEOUT_EN.
module pkt_release_scheduler #(
    parameter int PEND_DEPTH = 8,
    parameter int PEND_W     = 4,
    parameter int TIMEOUT    = 1023,
    parameter int TMO_W      = 10,
    parameter int PORT_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pkt_done,
    input  logic              act_valid,
    output logic              act_ready,
    input  logic              act_drop,
    input  logic [PORT_W-1:0] act_port,
    output logic              pkt_ready_to_send,
    input  logic              buf_rd_valid,
    input  logic              buf_rd_last,
    output logic              egress_en,
    output logic [PORT_W-1:0] egress_port,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow,
    output logic [15:0]       fwd_cnt,
    output logic [15:0]       drop_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_ACT, S_ISSUE, S_DRAIN} state_t;

    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_DEPTH);

    state_t              state_q, state_d;
    logic                pulse_q, pulse_d;
    logic                en_q, en_d;
    logic [PORT_W-1:0]   port_q, port_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         fwd_q, fwd_d;
    logic [15:0]         drop_q, drop_d;
    logic                pkt_last;

`ifdef ACT_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0]    tmr_q, tmr_d;
`else
    logic                unused_tmo_cfg;
    assign unused_tmo_cfg = ^TMO_W'(TIMEOUT);
`endif

    // Last byte only counts while a drain is actually being tracked.
    assign pkt_last = (state_q == S_DRAIN) && buf_rd_valid && buf_rd_last;

    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        en_d    = en_q;
        port_d  = port_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        fwd_d   = fwd_q;
        drop_d  = drop_q;
`ifdef ACT_TIMEOUT_EN
        tmr_d   = tmr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pend_q != '0) begin
                    state_d = S_WAIT_ACT;
`ifdef ACT_TIMEOUT_EN
                    tmr_d   = '0;
`endif
                end
            end
            S_WAIT_ACT: begin
                if (act_valid) begin
                    state_d = S_ISSUE;
                    pulse_d = 1'b1;
                    en_d    = ~act_drop;
                    port_d  = act_port;
                end
`ifdef ACT_TIMEOUT_EN
                else if (tmr_q == TMO_LAST) begin
                    state_d = S_ISSUE;
                    pulse_d = 1'b1;
                    en_d    = 1'b0;
                end else begin
                    tmr_d   = tmr_q + 1'b1;
                end
`endif
            end
            S_ISSUE: state_d = S_DRAIN;
            S_DRAIN: begin
                if (pkt_last) begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                    if (en_q) fwd_d  = fwd_q + 16'd1;
                    else      drop_d = drop_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Arrival and completion in the same cycle cancel out.
        if (pkt_done && !pkt_last) begin
            if (pend_q == PEND_FULL) ovf_d  = 1'b1;
            else                     pend_d = pend_q + 1'b1;
        end else if (!pkt_done && pkt_last) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pulse_q <= 1'b0;
            en_q    <= 1'b0;
            port_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            fwd_q   <= '0;
            drop_q  <= '0;
`ifdef ACT_TIMEOUT_EN
            tmr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            en_q    <= en_d;
            port_q  <= port_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            fwd_q   <= fwd_d;
            drop_q  <= drop_d;
`ifdef ACT_TIMEOUT_EN
            tmr_q   <= tmr_d;
`endif
        end
    end

    assign act_ready         = (state_q == S_WAIT_ACT);
    assign busy              = (state_q != S_IDLE);
    assign pkt_ready_to_send = pulse_q;
    assign egress_en         = en_q;
    assign egress_port       = port_q;
    assign pend_cnt          = pend_q;
    assign overflow          = ovf_q;
    assign fwd_cnt           = fwd_q;
    assign drop_cnt          = drop_q;

endmodule

// File: tb/tb_pkt_release_scheduler.sv
// Bench for pkt_release_scheduler: per-cycle vector table plus directed multi-cycle sequences.
module tb_pkt_release_scheduler;

`ifdef ACT_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1023;
`endif

    logic        clk = 1'b0;
    logic        rst_n, pkt_done, act_valid, act_drop, buf_rd_valid, buf_rd_last;
    logic [1:0]  act_port;
    logic        act_ready, pkt_ready_to_send, egress_en, busy, overflow;
    logic [1:0]  egress_port;
    logic [3:0]  pend_cnt;
    logic [15:0] fwd_cnt, drop_cnt;

    always #5 clk = ~clk;

    pkt_release_scheduler #(
        .PEND_DEPTH(8), .PEND_W(4), .TIMEOUT(TMO), .TMO_W(10), .PORT_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pkt_done(pkt_done),
        .act_valid(act_valid), .act_ready(act_ready), .act_drop(act_drop), .act_port(act_port),
        .pkt_ready_to_send(pkt_ready_to_send),
        .buf_rd_valid(buf_rd_valid), .buf_rd_last(buf_rd_last),
        .egress_en(egress_en), .egress_port(egress_port), .busy(busy),
        .pend_cnt(pend_cnt), .overflow(overflow), .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst_n, pd, av, ad;
        logic [1:0]  ap;
        logic        rv, rl;
        logic        e_rdy, e_pulse, e_en;
        logic [1:0]  e_port;
        logic        e_busy;
        logic [3:0]  e_pend;
        logic [15:0] e_fwd, e_drop;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input int r, pd, av, ad, ap, rv, rl,
                                input int rdy, pu, en, pt, bz, pe, fw, dr, ov);
        vec_t v;
        v.rst_n = 1'(r);   v.pd = 1'(pd);   v.av = 1'(av);    v.ad = 1'(ad);
        v.ap = 2'(ap);     v.rv = 1'(rv);   v.rl = 1'(rl);
        v.e_rdy = 1'(rdy); v.e_pulse = 1'(pu); v.e_en = 1'(en); v.e_port = 2'(pt);
        v.e_busy = 1'(bz); v.e_pend = 4'(pe); v.e_fwd = 16'(fw); v.e_drop = 16'(dr);
        v.e_ovf = 1'(ov);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        pkt_done = 0; act_valid = 0; act_drop = 0; act_port = 0;
        buf_rd_valid = 0; buf_rd_last = 0;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic one_done();
        pkt_done = 1;
        tick();
        pkt_done = 0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!act_ready && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".ready"}, 32'(act_ready), 1);
    endtask

    task automatic decide(input logic drop, input logic [1:0] port, input string tag);
        wait_ready(tag);
        act_valid = 1; act_drop = drop; act_port = port;
        tick();
        act_valid = 0; act_drop = 0; act_port = 0;
        chk({tag, ".pulse"}, 32'(pkt_ready_to_send), 1);
        chk({tag, ".en"}, 32'(egress_en), 32'(!drop));
        chk({tag, ".port"}, 32'(egress_port), 32'(port));
    endtask

    // One gap cycle after the pulse, then nbytes with last on the final one.
    task automatic drain(input int nbytes, input logic pd_on_last, input logic exp_en,
                         input logic [1:0] exp_port, input string tag);
        int good = 0;
        int pulses = 0;
        tick();
        pulses += int'(pkt_ready_to_send);
        for (int b = 0; b < nbytes; b++) begin
            buf_rd_valid = 1;
            buf_rd_last  = (b == nbytes - 1);
            pkt_done     = pd_on_last && (b == nbytes - 1);
            if (egress_en == exp_en && egress_port == exp_port) good++;
            tick();
            pulses += int'(pkt_ready_to_send);
        end
        clr_in();
        chk({tag, ".bytes_gated"}, 32'(good), 32'(nbytes));
        chk({tag, ".extra_pulses"}, 32'(pulses), 0);
        chk({tag, ".en_after"}, 32'(egress_en), 0);
    endtask

    initial begin
        clr_in();
        rst_n = 1;

        //               r pd av ad ap rv rl | rdy pu en pt bz pe fw dr ov
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[3]  = mk(1, 0, 1, 0, 2, 0, 0,   0, 1, 1, 2, 1, 1, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 2, 1, 1, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 1, 0,   0, 0, 1, 2, 1, 1, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 1, 1,   0, 0, 0, 2, 0, 0, 1, 0, 0);
        tbl[7]  = mk(1, 0, 1, 1, 3, 0, 0,   0, 0, 0, 2, 0, 0, 1, 0, 0);
        tbl[8]  = mk(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0, 1, 1, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2, 1, 1, 1, 0, 0);
        tbl[10] = mk(1, 0, 1, 1, 3, 0, 0,   0, 1, 0, 3, 1, 1, 1, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 0, 1, 1,   0, 0, 0, 3, 1, 1, 1, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 3, 1, 1, 1, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, 1, 1,   0, 0, 0, 3, 0, 0, 1, 1, 0);

        for (int i = 0; i < 14; i++) begin
            rst_n = tbl[i].rst_n; pkt_done = tbl[i].pd; act_valid = tbl[i].av;
            act_drop = tbl[i].ad; act_port = tbl[i].ap;
            buf_rd_valid = tbl[i].rv; buf_rd_last = tbl[i].rl;
            tick();
            chk($sformatf("v%0d.ready", i), 32'(act_ready),         32'(tbl[i].e_rdy));
            chk($sformatf("v%0d.pulse", i), 32'(pkt_ready_to_send), 32'(tbl[i].e_pulse));
            chk($sformatf("v%0d.en", i),    32'(egress_en),         32'(tbl[i].e_en));
            chk($sformatf("v%0d.port", i),  32'(egress_port),       32'(tbl[i].e_port));
            chk($sformatf("v%0d.busy", i),  32'(busy),              32'(tbl[i].e_busy));
            chk($sformatf("v%0d.pend", i),  32'(pend_cnt),          32'(tbl[i].e_pend));
            chk($sformatf("v%0d.fwd", i),   32'(fwd_cnt),           32'(tbl[i].e_fwd));
            chk($sformatf("v%0d.drop", i),  32'(drop_cnt),          32'(tbl[i].e_drop));
            chk($sformatf("v%0d.ovf", i),   32'(overflow),          32'(tbl[i].e_ovf));
        end
        clr_in();
        rst_n = 1;

        // 64-byte forward after a 5-cycle decision delay
        do_reset();
        one_done();
        wait_ready("t1");
        repeat (5) tick();
        chk("t1.still_waiting", 32'(act_ready), 1);
        decide(0, 2, "t1");
        drain(64, 0, 1, 2, "t1");
        chk("t1.fwd", 32'(fwd_cnt), 1);
        chk("t1.drop", 32'(drop_cnt), 0);
        chk("t1.pend", 32'(pend_cnt), 0);

        // 40-byte drop
        do_reset();
        one_done();
        decide(1, 1, "t2");
        drain(40, 0, 0, 1, "t2");
        chk("t2.drop", 32'(drop_cnt), 1);
        chk("t2.fwd", 32'(fwd_cnt), 0);

        // three queued packets, decisions in order
        do_reset();
        repeat (3) begin
            pkt_done = 1;
            tick();
        end
        pkt_done = 0;
        chk("t3.pend3", 32'(pend_cnt), 3);
        decide(0, 1, "t3a");
        drain(4, 0, 1, 1, "t3a");
        chk("t3.pend2", 32'(pend_cnt), 2);
        decide(1, 0, "t3b");
        drain(4, 0, 0, 0, "t3b");
        chk("t3.pend1", 32'(pend_cnt), 1);
        decide(0, 3, "t3c");
        drain(4, 0, 1, 3, "t3c");
        chk("t3.pend0", 32'(pend_cnt), 0);
        chk("t3.fwd", 32'(fwd_cnt), 2);
        chk("t3.drop", 32'(drop_cnt), 1);

        // arrival coincident with last byte, then saturation
        do_reset();
        one_done();
        decide(0, 0, "t4");
        drain(5, 1, 1, 0, "t4");
        chk("t4.pend_same", 32'(pend_cnt), 1);
        chk("t4.idle", 32'(busy), 0);
        tick();
        chk("t4.rewait", 32'(act_ready), 1);
        repeat (7) one_done();
        chk("t4.pend8", 32'(pend_cnt), 8);
        chk("t4.no_ovf", 32'(overflow), 0);
        one_done();
        chk("t4.pend_sat", 32'(pend_cnt), 8);
        chk("t4.ovf", 32'(overflow), 1);
        repeat (3) tick();
        chk("t4.ovf_sticky", 32'(overflow), 1);
        do_reset();
        chk("t4.ovf_cleared", 32'(overflow), 0);
        chk("t4.pend_cleared", 32'(pend_cnt), 0);

`ifdef ACT_TIMEOUT_EN
        begin
            int cnt = 0;
            one_done();
            wait_ready("t5");
            while (!pkt_ready_to_send && cnt < 40) begin
                tick();
                cnt++;
            end
            chk("t5.tmo_cycles", 32'(cnt), 16);
            chk("t5.tmo_en", 32'(egress_en), 0);
            drain(3, 0, 0, 0, "t5");
            chk("t5.drop", 32'(drop_cnt), 1);
            one_done();
            wait_ready("t5b");
            repeat (15) tick();
            chk("t5b.no_pulse_yet", 32'(pkt_ready_to_send), 0);
            act_valid = 1; act_drop = 0; act_port = 1;
            tick();
            act_valid = 0; act_port = 0;
            chk("t5b.pulse", 32'(pkt_ready_to_send), 1);
            chk("t5b.en", 32'(egress_en), 1);
            chk("t5b.port", 32'(egress_port), 1);
            drain(3, 0, 1, 1, "t5b");
            chk("t5b.fwd", 32'(fwd_cnt), 1);
            chk("t5b.drop", 32'(drop_cnt), 1);
        end
`else
        begin
            int pulses = 0;
            one_done();
            wait_ready("t5");
            repeat (40) begin
                tick();
                pulses += int'(pkt_ready_to_send);
            end
            chk("t5.no_tmo_pulse", 32'(pulses), 0);
            chk("t5.still_waiting", 32'(act_ready), 1);
            decide(0, 3, "t5");
            drain(3, 0, 1, 3, "t5");
            chk("t5.fwd", 32'(fwd_cnt), 1);
        end
`endif

        // reset in the middle of a 64-byte drain
        do_reset();
        one_done();
        decide(0, 2, "t6");
        tick();
        for (int b = 0; b < 10; b++) begin
            buf_rd_valid = 1;
            tick();
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        clr_in();
        chk("t6.busy", 32'(busy), 0);
        chk("t6.ready", 32'(act_ready), 0);
        chk("t6.en", 32'(egress_en), 0);
        chk("t6.port", 32'(egress_port), 0);
        chk("t6.pend", 32'(pend_cnt), 0);
        chk("t6.pulse", 32'(pkt_ready_to_send), 0);
        one_done();
        decide(0, 1, "t6b");
        drain(3, 0, 1, 1, "t6b");
        chk("t6b.fwd", 32'(fwd_cnt), 1);
        chk("t6b.pend", 32'(pend_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pkt_release_scheduler.md
Name: pkt_release_scheduler

Overview:
Sequences the packet buffer FIFO's hold/release cycle.
- Counts packets fully written into the buffer.
- Pairs each one, in order, with the TCAM action decision.
- Pulses the buffer's release input, then tracks the drain until the last byte.
- Drives the egress gate and port select so that dropped packets are drained but never forwarded.
- Sits between the TCAM/action stage, the buffer FIFO and the egress mux.

Parameters:
PEND_DEPTH, 8, max completed-but-unreleased packets tracked
PEND_W, 4, width of pending counter (holds 0..PEND_DEPTH)
TIMEOUT, 1023, cycles waited in WAIT_ACT before forced drop
TMO_W, 10, width of timeout counter
PORT_W, 2, egress port index width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
pkt_done  in  1  write side wr_valid&wr_last, one pulse per stored packet
act_valid  in  1  action decision valid
act_ready  out  1  scheduler accepts decision (combinational, =1 only in WAIT_ACT)
act_drop  in  1  1 = drop packet, 0 = forward
act_port  in  PORT_W  egress port for forward
pkt_ready_to_send  out  1  registered single-cycle release pulse to buffer
buf_rd_valid  in  1  buffer output byte valid
buf_rd_last  in  1  buffer output end-of-packet
egress_en  out  1  1 = buffer bytes are forwarded; 0 = discarded
egress_port  out  PORT_W  latched port for current packet
busy  out  1  FSM not in IDLE
pend_cnt  out  PEND_W  packets stored, not yet fully drained
overflow  out  1  sticky: pkt_done arrived with pend_cnt==PEND_DEPTH
fwd_cnt  out  16  forwarded packets, wraps
drop_cnt  out  16  dropped packets (incl. timeouts), wraps

Behaviour:
Reset (synchronous, rst_n=0 at posedge clk):
- FSM to IDLE.
- All registered outputs and counters 0; overflow cleared.
- Applies mid-packet too. The buffer shares rst_n, so both restart clean with no partial drain tracked.

FSM (4 states):
- IDLE: busy=0. If pend_cnt>0, go to WAIT_ACT and clear the timer.
- WAIT_ACT: act_ready=1.
  - act_valid=1: latch act_drop and act_port; go to ISSUE next cycle.
  - Otherwise timer increments. When the timer reaches TIMEOUT-1 without act_valid: latch drop=1, go to ISSUE.
  - act_valid in the same cycle as the timeout wins (decision used).
- ISSUE: for one cycle, register pkt_ready_to_send=1, egress_en=~drop and egress_port=latched port. Go to DRAIN.
- DRAIN:
  - pkt_ready_to_send=0.
  - egress_en and egress_port hold stable for the entire drain. The buffer's first rd_valid appears 2 cycles after the pulse.
  - On buf_rd_valid&buf_rd_last: decrement pend_cnt; increment fwd_cnt (forward) or drop_cnt (drop); clear egress_en on the next edge; go to IDLE.

Timing and interface rules:
- Minimum turnaround: 1 idle cycle between packets (IDLE->WAIT_ACT). The buffer returns to COLLECT after the last byte, so no back-to-back pulse is issued.
- act_valid outside WAIT_ACT is ignored (act_ready=0). The decision source must hold act_valid until act_ready.

pend_cnt update:
- pkt_done alone: +1.
- Drain completion alone: -1.
- Both in the same cycle: unchanged.
- pkt_done with pend_cnt==PEND_DEPTH and no decrement: saturate, set overflow (sticky until reset).

Error tolerance:
- buf_rd_valid outside DRAIN is ignored.
- buf_rd_last without buf_rd_valid is ignored.

Counters are 16-bit and wrap 0xFFFF->0.

Optional Feature:
ACT_TIMEOUT_EN:
- Defined: WAIT_ACT timeout active as above; the forced drop counts in drop_cnt.
- Undefined: the timer is not built; WAIT_ACT waits indefinitely for act_valid; TIMEOUT/TMO_W unused.

Test Plan:
1. One 64-byte packet: pkt_done, then act_valid forward port=2 after 5 cycles -> pkt_ready_to_send pulses once; egress_en=1 and egress_port=2 through all 64 bytes; fwd_cnt=1; pend_cnt back to 0.
2. Drop action: act_drop=1 -> release pulse still issued; 40 bytes drained with egress_en=0; drop_cnt=1, fwd_cnt=0.
3. Three pkt_done pulses before any decision; decisions fwd p1, drop, fwd p3 -> exactly three release pulses in order with matching egress_en/egress_port; pend_cnt goes 3,2,1,0.
4. pkt_done coincident with buf_rd_last of the packet being drained -> pend_cnt unchanged, next WAIT_ACT entered; 9th pkt_done with pend_cnt=8 -> overflow=1, pend_cnt stays 8.
5. ACT_TIMEOUT_EN defined, TIMEOUT=16, no act_valid -> forced drop issued 16 cycles after WAIT_ACT entry, drop_cnt=1; act_valid on the timeout cycle -> decision used.
6. rst_n low mid-drain (byte 10 of 64) -> next cycle all outputs 0, FSM IDLE; a fresh packet then forwards normally.
